wb_port_arbiter: RTL and testbench

Writeback-port arbiter between the execute pipes and the physical register file. Each execute pipe delivers at most one result per cycle into a one-entry holding slot; the arbiter grants up to NUM_WB_PORTS held results per cycle in round-robin order onto registered writeback/bypass ports. When a pipe's slot cannot drain, the arbiter back-pressures that pipe, so no result is ever dropped except on flush or reset.

---
 rtl/wb_port_arbiter_if.sv | 36 +++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the execute-pipe result handshake and the registered writeback ports
// of wb_port_arbiter.
//   master : execute side plus register file / bypass consumer (drives ex_*,
//            observes ex_ready and wb_*)
//   slave  : the arbiter
// Signals:
//   ex_valid / ex_dst / ex_value : one result offer per pipe per cycle
//   ex_ready                     : offer from pipe i is taken this cycle
//   wb_valid / wb_dst / wb_value : registered writeback / bypass ports
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int NUM_EX_PIPES = 4,
  parameter int NUM_WB_PORTS = 2,
  parameter int PREG_W       = 7,
  parameter int DATA_W       = 32
);
  logic [NUM_EX_PIPES-1:0]             ex_valid;
  logic [NUM_EX_PIPES-1:0][PREG_W-1:0] ex_dst;
  logic [NUM_EX_PIPES-1:0][DATA_W-1:0] ex_value;
  logic [NUM_EX_PIPES-1:0]             ex_ready;
  logic [NUM_WB_PORTS-1:0]             wb_valid;
  logic [NUM_WB_PORTS-1:0][PREG_W-1:0] wb_dst;
  logic [NUM_WB_PORTS-1:0][DATA_W-1:0] wb_value;

  modport master (
    output ex_valid, ex_dst, ex_value,
    input  ex_ready, wb_valid, wb_dst, wb_value
  );

  modport slave (
    input  ex_valid, ex_dst, ex_value,
    output ex_ready, wb_valid, wb_dst, wb_value
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Each execute pipe owns a one-entry holding slot. Every cycle up to
// NUM_WB_PORTS held results are granted in round-robin order and registered
// onto the writeback/bypass ports. A pipe whose slot stays occupied sees
// ex_ready low, so results are only ever lost to flush or reset.
// Ports:
//   i_clk       : clock, all state on rising edge
//   i_rst       : asynchronous active-high reset
//   i_flush     : synchronous squash of held and in-flight results
//   bus         : wb_port_arbiter_if.slave (ex_* handshake, wb_* outputs)
//   o_stall_cnt : saturating count of cycles with a back-pressured offer
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int NUM_EX_PIPES = 4,
  parameter int NUM_WB_PORTS = 2,
  parameter int PREG_W       = 7,
  parameter int DATA_W       = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  wb_port_arbiter_if.slave         bus,
  output logic [15:0]              o_stall_cnt
);

  localparam int PTR_W = (NUM_EX_PIPES > 1) ? $clog2(NUM_EX_PIPES) : 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   sum_t;

  logic [NUM_EX_PIPES-1:0]             r_held_valid;
  logic [NUM_EX_PIPES-1:0][PREG_W-1:0] r_held_dst;
  logic [NUM_EX_PIPES-1:0][DATA_W-1:0] r_held_value;
  ptr_t                                r_rr_ptr;
  logic [15:0]                         r_stall_cnt;
  logic [NUM_WB_PORTS-1:0]             r_wb_valid;
  logic [NUM_WB_PORTS-1:0][PREG_W-1:0] r_wb_dst;
  logic [NUM_WB_PORTS-1:0][DATA_W-1:0] r_wb_value;

  logic [NUM_EX_PIPES-1:0] w_grant;
  logic [NUM_WB_PORTS-1:0] w_port_vld;
  ptr_t                    w_port_sel [NUM_WB_PORTS];
  ptr_t                    w_rr_next;
  logic [NUM_EX_PIPES-1:0] w_ready;
  logic [NUM_EX_PIPES-1:0] w_accept;
  logic                    w_stall;

  // Round-robin scan starting at r_rr_ptr; the k-th held slot found goes to
  // port k until the ports run out.
  always_comb begin
    sum_t sum;
    ptr_t idx;
    int   n_gr;
    // NOTE: every combinational output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    w_grant    = '0;
    w_port_vld = '0;
    w_rr_next  = r_rr_ptr;
    n_gr       = 0;
    for (int p = 0; p < NUM_WB_PORTS; p++) w_port_sel[p] = '0;
    for (int k = 0; k < NUM_EX_PIPES; k++) begin
      sum = {1'b0, r_rr_ptr} + sum_t'(k);
      if (sum >= sum_t'(NUM_EX_PIPES)) sum = sum - sum_t'(NUM_EX_PIPES);
      idx = sum[PTR_W-1:0];
      if (r_held_valid[idx] && n_gr < NUM_WB_PORTS) begin
        w_grant[idx] = 1'b1;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
          if (p == n_gr) begin
            w_port_vld[p] = 1'b1;
            w_port_sel[p] = idx;
          end
        end
        w_rr_next = (idx == ptr_t'(NUM_EX_PIPES - 1)) ? '0 : idx + ptr_t'(1);
        n_gr      = n_gr + 1;
      end
    end
  end

  // A granted slot drains this cycle, so it can take a new result at the same
  // edge. Flush opens every slot because whatever arrives is discarded anyway.
  always_comb begin
    if (i_rst)        w_ready = '0;
    else if (i_flush) w_ready = '1;
    else              w_ready = ~r_held_valid | w_grant;
  end

  assign w_accept = bus.ex_valid & w_ready;
  assign w_stall  = |(bus.ex_valid & ~w_ready);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process order.
  // NOTE: the slot payload is reset together with its valid bit; it is small
  // and keeps the writeback ports free of unknowns after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_held_valid <= '0;
      r_held_dst   <= '0;
      r_held_value <= '0;
    end else if (i_flush) begin
      r_held_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_EX_PIPES; i++) begin
        if (w_accept[i]) begin
          r_held_valid[i] <= 1'b1;
          r_held_dst[i]   <= bus.ex_dst[i];
          r_held_value[i] <= bus.ex_value[i];
        end else if (w_grant[i]) begin
          r_held_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Invalid ports keep their last dst/value so the bypass network sees stable
  // data; only wb_valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb_valid <= '0;
      r_wb_dst   <= '0;
      r_wb_value <= '0;
    end else if (i_flush) begin
      r_wb_valid <= '0;
    end else begin
      r_wb_valid <= w_port_vld;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (w_port_vld[p]) begin
          r_wb_dst[p]   <= r_held_dst[w_port_sel[p]];
          r_wb_value[p] <= r_held_value[w_port_sel[p]];
        end
      end
    end
  end

  // Pointer and stall counter are frozen during a flush cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
    end else if (!i_flush) begin
      r_rr_ptr <= w_rr_next;
      if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.ex_ready = w_ready;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_dst   = r_wb_dst;
  assign bus.wb_value = r_wb_value;
  assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios for wb_port_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int PW = 7;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  int          total = 0;
  int          bad = 0;

  wb_port_arbiter_if #(.NUM_EX_PIPES(N), .NUM_WB_PORTS(P), .PREG_W(PW), .DATA_W(DW)) bus ();

  wb_port_arbiter #(.NUM_EX_PIPES(N), .NUM_WB_PORTS(P), .PREG_W(PW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .bus         (bus.slave),
    .o_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = '0;
    bus.ex_dst   = '0;
    bus.ex_value = '0;
    flush        = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #2;
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL reset_wbv got=%b exp=00", bus.wb_valid); end
    total++; if (bus.ex_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.ex_ready); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", stall_cnt); end
    total++; if (bus.wb_dst[0] !== 7'd0 || bus.wb_value[1] !== 32'd0) begin bad++; $display("FAIL reset_wbdata got=%0h/%0h exp=0/0", bus.wb_dst[0], bus.wb_value[1]); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL reset_idle_wbv got=%b exp=00", bus.wb_valid); end
  endtask

  task automatic test_single();
    bus.ex_valid    = 4'b0100;
    bus.ex_dst[2]   = 7'd5;
    bus.ex_value[2] = 32'hDEADBEEF;
    #1;
    total++; if (bus.ex_ready !== 4'b1111) begin bad++; $display("FAIL single_ready got=%b exp=1111", bus.ex_ready); end
    tick();
    idle_inputs();
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL single_c1_wbv got=%b exp=00", bus.wb_valid); end
    tick();
    total++; if (bus.wb_valid !== 2'b01) begin bad++; $display("FAIL single_wbv got=%b exp=01", bus.wb_valid); end
    total++; if (bus.wb_dst[0] !== 7'd5) begin bad++; $display("FAIL single_dst got=%0d exp=5", bus.wb_dst[0]); end
    total++; if (bus.wb_value[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_value got=%h exp=deadbeef", bus.wb_value[0]); end
    total++; if (dut.r_rr_ptr !== 2'd3) begin bad++; $display("FAIL single_rr got=%0d exp=3", dut.r_rr_ptr); end
    tick();
    total++; if (bus.wb_valid !== 2'b00 || bus.wb_dst[0] !== 7'd5) begin bad++; $display("FAIL single_hold got=%b/%0d exp=00/5", bus.wb_valid, bus.wb_dst[0]); end
  endtask

  task automatic test_burst();
    apply_reset();
    bus.ex_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.ex_dst[i]   = 7'(10 + i);
      bus.ex_value[i] = 32'hA0 + 32'(i);
    end
    tick();
    idle_inputs();
    total++; if (bus.ex_ready !== 4'b0011) begin bad++; $display("FAIL burst_c1_ready got=%b exp=0011", bus.ex_ready); end
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL burst_c1_wbv got=%b exp=00", bus.wb_valid); end
    tick();
    total++; if (bus.wb_valid !== 2'b11) begin bad++; $display("FAIL burst_c2_wbv got=%b exp=11", bus.wb_valid); end
    total++; if (bus.wb_dst[0] !== 7'd10 || bus.wb_dst[1] !== 7'd11) begin bad++; $display("FAIL burst_c2_dst got=%0d,%0d exp=10,11", bus.wb_dst[0], bus.wb_dst[1]); end
    total++; if (bus.wb_value[1] !== 32'hA1) begin bad++; $display("FAIL burst_c2_value got=%h exp=a1", bus.wb_value[1]); end
    tick();
    total++; if (bus.wb_valid !== 2'b11) begin bad++; $display("FAIL burst_c3_wbv got=%b exp=11", bus.wb_valid); end
    total++; if (bus.wb_dst[0] !== 7'd12 || bus.wb_dst[1] !== 7'd13) begin bad++; $display("FAIL burst_c3_dst got=%0d,%0d exp=12,13", bus.wb_dst[0], bus.wb_dst[1]); end
    total++; if (bus.wb_value[0] !== 32'hA2) begin bad++; $display("FAIL burst_c3_value got=%h exp=a2", bus.wb_value[0]); end
    total++; if (dut.r_rr_ptr !== 2'd0) begin bad++; $display("FAIL burst_rr got=%0d exp=0", dut.r_rr_ptr); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL burst_stall got=%0d exp=0", stall_cnt); end
    tick();
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL burst_c4_wbv got=%b exp=00", bus.wb_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ready [1:5];
    int         exp_p0 [2:5];
    int         exp_p1 [2:5];
    exp_ready = '{4'b1011, 4'b1101, 4'b1110, 4'b1011, 4'b1101};
    exp_p0    = '{0, 2, 1, 0};
    exp_p1    = '{1, 0, 2, 1};
    apply_reset();
    bus.ex_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      bus.ex_dst[i]   = 7'(i);
      bus.ex_value[i] = 32'h1000 + 32'(i);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++; if (bus.ex_ready !== exp_ready[c]) begin bad++; $display("FAIL fair_ready c%0d got=%b exp=%b", c, bus.ex_ready, exp_ready[c]); end
      total++; if (stall_cnt !== 16'(c - 1)) begin bad++; $display("FAIL fair_stall c%0d got=%0d exp=%0d", c, stall_cnt, c - 1); end
      if (c >= 2) begin
        total++; if (bus.wb_valid !== 2'b11) begin bad++; $display("FAIL fair_wbv c%0d got=%b exp=11", c, bus.wb_valid); end
        total++; if (bus.wb_dst[0] !== 7'(exp_p0[c]) || bus.wb_dst[1] !== 7'(exp_p1[c])) begin bad++; $display("FAIL fair_pair c%0d got=%0d,%0d exp=%0d,%0d", c, bus.wb_dst[0], bus.wb_dst[1], exp_p0[c], exp_p1[c]); end
        total++; if (bus.wb_value[0] !== 32'h1000 + 32'(exp_p0[c])) begin bad++; $display("FAIL fair_value c%0d got=%h exp=%h", c, bus.wb_value[0], 32'h1000 + 32'(exp_p0[c])); end
      end
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    bus.ex_valid    = 4'b0001;
    bus.ex_dst[0]   = 7'd9;
    bus.ex_value[0] = 32'h900;
    tick();
    idle_inputs();
    tick();
    total++; if (bus.wb_dst[0] !== 7'd9 || dut.r_rr_ptr !== 2'd1) begin bad++; $display("FAIL flush_pre got=%0d/rr%0d exp=9/rr1", bus.wb_dst[0], dut.r_rr_ptr); end
    bus.ex_valid    = 4'b1010;
    bus.ex_dst[1]   = 7'd33;
    bus.ex_value[1] = 32'h111;
    bus.ex_dst[3]   = 7'd35;
    bus.ex_value[3] = 32'h333;
    tick();
    idle_inputs();
    flush           = 1'b1;
    bus.ex_valid    = 4'b0010;
    bus.ex_dst[1]   = 7'd44;
    bus.ex_value[1] = 32'hBAD;
    #1;
    total++; if (bus.ex_ready !== 4'b1111) begin bad++; $display("FAIL flush_ready got=%b exp=1111", bus.ex_ready); end
    tick();
    idle_inputs();
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL flush_f1_wbv got=%b exp=00", bus.wb_valid); end
    total++; if (dut.r_rr_ptr !== 2'd1) begin bad++; $display("FAIL flush_rr got=%0d exp=1", dut.r_rr_ptr); end
    total++; if (bus.wb_dst[0] !== 7'd9) begin bad++; $display("FAIL flush_hold got=%0d exp=9", bus.wb_dst[0]); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL flush_stall got=%0d exp=0", stall_cnt); end
    for (int c = 2; c <= 3; c++) begin
      tick();
      total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL flush_f%0d_wbv got=%b exp=00", c, bus.wb_valid); end
    end
  endtask

  task automatic test_saturation();
    int p0;
    apply_reset();
    bus.ex_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.ex_dst[i]   = 7'(20 + i);
      bus.ex_value[i] = 32'hC000 + 32'(i);
    end
    for (int c = 1; c <= 65600; c++) begin
      tick();
      if (c == 65530) begin
        total++; if (stall_cnt !== 16'd65529) begin bad++; $display("FAIL sat_count got=%0d exp=65529", stall_cnt); end
      end
    end
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_max got=%h exp=ffff", stall_cnt); end
    for (int c = 65601; c <= 65604; c++) begin
      tick();
      p0 = (c % 2 == 0) ? 0 : 2;
      total++; if (bus.wb_valid !== 2'b11) begin bad++; $display("FAIL sat_wbv c%0d got=%b exp=11", c, bus.wb_valid); end
      total++; if (bus.wb_dst[0] !== 7'(20 + p0) || bus.wb_dst[1] !== 7'(21 + p0)) begin bad++; $display("FAIL sat_pair c%0d got=%0d,%0d exp=%0d,%0d", c, bus.wb_dst[0], bus.wb_dst[1], 20 + p0, 21 + p0); end
      total++; if (bus.wb_value[1] !== 32'hC001 + 32'(p0)) begin bad++; $display("FAIL sat_value c%0d got=%h exp=%h", c, bus.wb_value[1], 32'hC001 + 32'(p0)); end
    end
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.ex_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.ex_dst[i]   = 7'(40 + i);
      bus.ex_value[i] = 32'hE0 + 32'(i);
    end
    tick();
    idle_inputs();
    tick();
    total++; if (bus.wb_valid !== 2'b11) begin bad++; $display("FAIL arst_pre_wbv got=%b exp=11", bus.wb_valid); end
    #3;
    rst   = 1'b1;
    flush = 1'b1;
    #1;
    total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL arst_wbv got=%b exp=00", bus.wb_valid); end
    total++; if (bus.ex_ready !== 4'b0000) begin bad++; $display("FAIL arst_ready got=%b exp=0000", bus.ex_ready); end
    total++; if (bus.wb_dst[0] !== 7'd0 || dut.r_rr_ptr !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d/rr%0d exp=0/rr0", bus.wb_dst[0], dut.r_rr_ptr); end
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (bus.wb_valid !== 2'b00) begin bad++; $display("FAIL arst_stale c%0d got=%b exp=00", c, bus.wb_valid); end
    end
    bus.ex_valid    = 4'b1000;
    bus.ex_dst[3]   = 7'd77;
    bus.ex_value[3] = 32'h7777;
    tick();
    idle_inputs();
    tick();
    total++; if (bus.wb_valid !== 2'b01 || bus.wb_dst[0] !== 7'd77 || bus.wb_value[0] !== 32'h7777) begin bad++; $display("FAIL arst_post got=%b/%0d/%h exp=01/77/7777", bus.wb_valid, bus.wb_dst[0], bus.wb_value[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fairness();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
